acq_capture_ctrl: RTL and testbench



---
 rtl/acq_pkg.sv | 17 +
 rtl/acq_capture_ctrl_if.sv | 27 ++
 rtl/acq_trig_detect.sv | 38 +++
 rtl/acq_capture_ctrl.sv | 154 +++++++++++++++
 tb/tb_acq_capture_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition capture controller.
// Holds the FSM state encoding and default buffer geometry.
package acq_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 10;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_READ  = 3'd4
    } acq_state_t;

endpackage

// File: rtl/acq_capture_ctrl_if.sv
// Buffer RAM port plus the valid/ready readout stream.
// The controller side is master; the RAM and the consumer sit on the slave side.
interface acq_capture_ctrl_if #(
    parameter int ADDR_W = acq_pkg::DEF_ADDR_W,
    parameter int DATA_W = acq_pkg::DEF_DATA_W
);

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic [DATA_W-1:0] sram_din;
    logic [ADDR_W-1:0] sram_addr_r;
    logic [DATA_W-1:0] sram_dout;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output sram_addr, sram_we, sram_din, sram_addr_r, rd_data, rd_valid,
        input  sram_dout, rd_ready
    );

    modport slave (
        input  sram_addr, sram_we, sram_din, sram_addr_r, rd_data, rd_valid,
        output sram_dout, rd_ready
    );

endinterface

// File: rtl/acq_trig_detect.sv
// Level-crossing trigger: compares the current sample with the previous written one.
// Combinational trig_o, no backpressure; clr_i invalidates the history on a new capture.
module acq_trig_detect
    import acq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              smp_vld_i,
    input  logic [DATA_W-1:0] smp_dat_i,
    input  logic [DATA_W-1:0] level_i,
    input  logic              rise_i,
    output logic              trig_o
);

    logic [DATA_W-1:0] prev_q;
    logic              prev_vld_q;
    logic              cur_above;
    logic              prev_above;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (smp_vld_i) begin
            prev_q     <= smp_dat_i;
            prev_vld_q <= 1'b1;
        end
    end

    assign cur_above  = (smp_dat_i >= level_i);
    assign prev_above = (prev_q >= level_i);
    assign trig_o     = prev_vld_q &&
                        (rise_i ? (!prev_above && cur_above) : (prev_above && !cur_above));

endmodule

// File: rtl/acq_capture_ctrl.sv
// Capture sequencer: pre-trigger fill, circular arm, post fill, chronological readout.
// Write 1 sample/cycle; readout zero-latency, stalls while rd_ready is low.
module acq_capture_ctrl
    import acq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_rise,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W-1:0] pretrig,
    input  logic [DATA_W-1:0] adc_data,
    acq_capture_ctrl_if.master bus,
    output logic              busy,
    output logic              done
);

    acq_state_t        state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] pretrig_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] level_q;
    logic              rise_q;
    logic              we_q;
    logic              rd_valid_q;
    logic              done_q;

    logic              arm_go;
    logic              trig;
    logic [ADDR_W-1:0] start_d;
    logic [ADDR_W-1:0] post_d;

    assign arm_go  = (state_q == ST_IDLE) && arm && !abort;
    assign start_d = wr_addr_q - pretrig_q;
    // Post window is (DEPTH-1) - pretrig, which is the bitwise inverse mod 2^ADDR_W.
    assign post_d  = ~pretrig_q;

    acq_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (arm_go),
        .smp_vld_i (we_q),
        .smp_dat_i (adc_data),
        .level_i   (level_q),
        .rise_i    (rise_q),
        .trig_o    (trig)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            start_q    <= '0;
            pretrig_q  <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            rise_q     <= 1'b0;
            we_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q    <= ST_IDLE;
                we_q       <= 1'b0;
                rd_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (arm) begin
                            pretrig_q <= pretrig;
                            level_q   <= trig_level;
                            rise_q    <= trig_rise;
                            wr_addr_q <= '0;
                            cnt_q     <= pretrig;
                            we_q      <= 1'b1;
                            state_q   <= (pretrig == '0) ? ST_ARMED : ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                        cnt_q     <= cnt_q - ADDR_W'(1);
                        if (cnt_q == ADDR_W'(1)) begin
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                        if (trig) begin
                            start_q <= start_d;
                            if (post_d == '0) begin
                                state_q    <= ST_READ;
                                we_q       <= 1'b0;
                                rd_valid_q <= 1'b1;
                                rd_addr_q  <= start_d;
                                cnt_q      <= '0;
                            end else begin
                                state_q <= ST_POST;
                                cnt_q   <= post_d;
                            end
                        end
                    end
                    ST_POST: begin
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                        cnt_q     <= cnt_q - ADDR_W'(1);
                        if (cnt_q == ADDR_W'(1)) begin
                            state_q    <= ST_READ;
                            we_q       <= 1'b0;
                            rd_valid_q <= 1'b1;
                            rd_addr_q  <= start_q;
                            cnt_q      <= '0;
                        end
                    end
                    ST_READ: begin
                        if (bus.rd_ready) begin
                            rd_addr_q <= rd_addr_q + ADDR_W'(1);
                            cnt_q     <= cnt_q + ADDR_W'(1);
                            // cnt_q counts completed transfers; all-ones means this is the last.
                            if (cnt_q == '1) begin
                                state_q    <= ST_IDLE;
                                rd_valid_q <= 1'b0;
                                done_q     <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        we_q       <= 1'b0;
                        rd_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sram_addr   = wr_addr_q;
    assign bus.sram_we     = we_q;
    assign bus.sram_din    = adc_data;
    assign bus.sram_addr_r = rd_addr_q;
    assign bus.rd_data     = bus.sram_dout;
    assign bus.rd_valid    = rd_valid_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Bench for acq_capture_ctrl: stream model predicts the captured window, scoreboard checks readout.
module tb_acq_capture_ctrl;
    import acq_pkg::*;

    localparam int AW = 11;
    localparam int DW = 10;
    localparam int NB = 2048;
    localparam int NS = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          abort;
    logic          trig_rise;
    logic [DW-1:0] trig_level;
    logic [AW-1:0] pretrig;
    logic [DW-1:0] adc_data;
    logic          rd_ready;
    logic          busy;
    logic          done;

    acq_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    acq_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .trig_rise  (trig_rise),
        .trig_level (trig_level),
        .pretrig    (pretrig),
        .adc_data   (adc_data),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [NB];
    always @(posedge clk) if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_din;
    assign bus.sram_dout = mem[bus.sram_addr_r];
    assign bus.rd_ready  = rd_ready;

    int total = 0;
    int bad   = 0;
    int stim [NS];
    int exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void fill(input int pat);
        for (int i = 0; i < NS; i++) begin
            case (pat)
                0: stim[i] = i % 1024;
                1: stim[i] = (i + 600) % 1024;
                2: stim[i] = (i < 5300) ? 400 + (i % 500) : (i % 250);
                default: stim[i] = int'($urandom_range(0, 1023));
            endcase
        end
    endfunction

    function automatic int find_trig(input int pt, input int lvl, input bit rise);
        bit a, b;
        for (int i = (pt > 0) ? pt : 1; i < NS; i++) begin
            a = stim[i-1] >= lvl;
            b = stim[i] >= lvl;
            if (rise ? (!a && b) : (a && !b)) return i;
        end
        return -1;
    endfunction

    // stop_kind: 0 = run to completion, 1 = abort in POST, 2 = rst after 500 transfers
    task automatic run_capture(input string nm, input int pt, input int lvl, input bit rise,
                               input int pat, input bit rnd_ready, input bit arm_mid,
                               input int stop_kind);
        int k, post, j_read, hs, dcnt, exp_v;
        logic [DW-1:0] held;
        bit stalled;
        fill(pat);
        k = find_trig(pt, lvl, rise);
        if (k < 0) begin
            $display("FAIL %s: no trigger in stimulus", nm);
            $fatal(1, "stimulus error");
        end
        post   = NB - 1 - pt;
        j_read = k + post + 1;
        exp_q.delete();
        for (int i = 0; i < NB; i++) exp_q.push_back(stim[k - pt + i]);

        pretrig    = AW'(pt);
        trig_level = DW'(lvl);
        trig_rise  = rise;
        arm        = 1'b1;
        rd_ready   = 1'b0;
        tick();
        arm = 1'b0;
        hs = 0; dcnt = 0; stalled = 0; held = '0;

        for (int j = 0; j < 30000; j++) begin
            adc_data = (j < NS) ? DW'(stim[j]) : '0;
            rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            arm      = arm_mid && (j == pt + 3);
            if (stop_kind == 1 && j == k + 10) abort = 1'b1;
            if (stop_kind == 2 && hs == 500) rst = 1'b1;
            @(negedge clk);
            if (j == 0) begin
                check_eq({nm, " first_we"}, 32'(bus.sram_we), 1);
                check_eq({nm, " first_addr"}, 32'(bus.sram_addr), 0);
                check_eq({nm, " busy"}, 32'(busy), 1);
            end
            if (j == j_read - 1 && stop_kind != 1)
                check_eq({nm, " early_valid"}, 32'(bus.rd_valid), 0);
            if (j == j_read) begin
                check_eq({nm, " read_valid"}, 32'(bus.rd_valid), 1);
                check_eq({nm, " read_we"}, 32'(bus.sram_we), 0);
                check_eq({nm, " start_addr"}, 32'(bus.sram_addr_r), (k - pt) & (NB - 1));
            end
            if (stalled && bus.rd_valid)
                check_eq({nm, " stall_hold"}, 32'(bus.rd_data), 32'(held));
            if (bus.rd_valid && rd_ready) begin
                exp_v = exp_q.pop_front();
                check_eq({nm, " data"}, 32'(bus.rd_data), exp_v);
                if (hs == pt) check_eq({nm, " trig_sample"}, 32'(bus.rd_data), stim[k]);
                hs++;
            end
            stalled = bus.rd_valid && !rd_ready;
            held    = bus.rd_data;
            if (done) dcnt++;

            if (abort || rst) begin
                tick();
                abort = 1'b0;
                rst   = 1'b0;
                arm   = 1'b0;
                @(negedge clk);
                check_eq({nm, " stop_busy"}, 32'(busy), 0);
                check_eq({nm, " stop_we"}, 32'(bus.sram_we), 0);
                check_eq({nm, " stop_valid"}, 32'(bus.rd_valid), 0);
                if (stop_kind == 2) begin
                    check_eq({nm, " rst_addr"}, 32'(bus.sram_addr), 0);
                    check_eq({nm, " rst_addr_r"}, 32'(bus.sram_addr_r), 0);
                end
                for (int c = 0; c < 6; c++) begin
                    if (done) dcnt++;
                    tick();
                    @(negedge clk);
                end
                check_eq({nm, " no_done"}, 32'(dcnt), 0);
                return;
            end

            if (hs == NB) begin
                tick();
                @(negedge clk);
                check_eq({nm, " done"}, 32'(done), 1);
                check_eq({nm, " idle_busy"}, 32'(busy), 0);
                check_eq({nm, " idle_valid"}, 32'(bus.rd_valid), 0);
                check_eq({nm, " early_done"}, 32'(dcnt), 0);
                tick();
                @(negedge clk);
                check_eq({nm, " done_pulse"}, 32'(done), 0);
                tick();
                return;
            end
            tick();
        end
        arm = 1'b0;
        check_eq({nm, " timeout_transfers"}, 32'(hs), NB);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) mem[i] = '0;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_rise = 1'b1;
        trig_level = '0; pretrig = '0; adc_data = '0; rd_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst busy", 32'(busy), 0);
        check_eq("rst done", 32'(done), 0);
        check_eq("rst we", 32'(bus.sram_we), 0);
        check_eq("rst valid", 32'(bus.rd_valid), 0);
        check_eq("rst addr", 32'(bus.sram_addr), 0);
        check_eq("rst addr_r", 32'(bus.sram_addr_r), 0);
        tick();
        rst = 1'b0;
        tick();

        run_capture("rise100",   100,  512, 1'b1, 0, 1'b0, 1'b0, 0);
        run_capture("pt0",       0,    512, 1'b1, 1, 1'b0, 1'b0, 0);
        run_capture("pt2047",    2047, 512, 1'b1, 0, 1'b0, 1'b0, 0);
        run_capture("wrap_fall", 300,  300, 1'b0, 2, 1'b0, 1'b1, 0);
        run_capture("bkpress",   1000, 200, 1'b1, 3, 1'b1, 1'b0, 0);
        run_capture("abort",     50,   512, 1'b1, 0, 1'b0, 1'b0, 1);
        run_capture("rst_read",  100,  512, 1'b1, 0, 1'b1, 1'b0, 2);
        run_capture("recapture", 7,    900, 1'b1, 1, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
